// File: rtl/voice_scheduler_if.sv
// Bundle between the voice scheduler, its event source, the wavetable ROM and the DAC path.
// slave is the scheduler side; master is everything around it.
interface voice_scheduler_if #(
    parameter int unsigned NUM_VOICES = 8,
    parameter int unsigned PHASE_W    = 32,
    parameter int unsigned ADDR_W     = 22,
    parameter int unsigned DATA_W     = 24
);
    localparam int unsigned MIX_W = DATA_W + $clog2(NUM_VOICES);

    logic                  sample_tick;
    logic                  evt_valid;
    logic                  evt_ready;
    logic                  evt_on;
    logic [6:0]            evt_note;
    logic [PHASE_W-1:0]    evt_freq;
    logic [ADDR_W-1:0]     rom_addr;
    logic [DATA_W-1:0]     rom_data;
    logic [MIX_W-1:0]      mix_out;
    logic                  mix_valid;
    logic [NUM_VOICES-1:0] voice_active;
    logic                  steal;
    logic                  tick_overrun;

    modport master (
        output sample_tick, evt_valid, evt_on, evt_note, evt_freq, rom_data,
        input  evt_ready, rom_addr, mix_out, mix_valid, voice_active, steal, tick_overrun
    );

    modport slave (
        input  sample_tick, evt_valid, evt_on, evt_note, evt_freq, rom_data,
        output evt_ready, rom_addr, mix_out, mix_valid, voice_active, steal, tick_overrun
    );
endinterface

// File: rtl/voice_scheduler.sv
// Polyphonic voice scheduler: allocates voices from note events and, per sample tick,
// walks every voice through the shared wavetable ROM port and emits one summed mix sample.
module voice_scheduler #(
    parameter int unsigned NUM_VOICES = 8,
    parameter int unsigned PHASE_W    = 32,
    parameter int unsigned ADDR_W     = 22,
    parameter int unsigned DATA_W     = 24,
    parameter int unsigned ROM_LAT    = 1
) (
    input logic              clk,
    input logic              reset,
    voice_scheduler_if.slave bus
);
    localparam int unsigned IDX_W = $clog2(NUM_VOICES);
    localparam int unsigned MIX_W = DATA_W + IDX_W;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t state, state_nx;

    logic [NUM_VOICES-1:0] active;
    logic [6:0]            note  [NUM_VOICES];
    logic [PHASE_W-1:0]    freq  [NUM_VOICES];
    logic [PHASE_W-1:0]    phase [NUM_VOICES];
    logic [IDX_W-1:0]      steal_ptr;
    logic [IDX_W-1:0]      issue_idx;

    // One slot per cycle of ROM latency plus the capture cycle
    logic [ROM_LAT:0]      pipe_busy;
    logic [ROM_LAT:0]      pipe_act;
    logic [MIX_W-1:0]      acc;

    logic                  evt_ready_c;
    logic                  start;
    logic                  issue;
    logic                  finish;
    logic                  evt_fire;
    logic                  push_act;
    logic                  last_issue;

    logic                  hit;
    logic [IDX_W-1:0]      hit_idx;
    logic                  free_found;
    logic [IDX_W-1:0]      free_idx;
    logic [NUM_VOICES-1:0] match_mask;
    logic [IDX_W-1:0]      on_idx;

    assign evt_fire   = bus.evt_valid && evt_ready_c;
    assign last_issue = (issue_idx == IDX_W'(NUM_VOICES - 1));
    assign push_act   = start ? active[0] : active[issue_idx];
    assign on_idx     = hit ? hit_idx : (free_found ? free_idx : steal_ptr);

    assign bus.evt_ready    = evt_ready_c;
    assign bus.voice_active = active;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (bus.sample_tick) state_nx = ISSUE;
            ISSUE:   if (last_issue) state_nx = DRAIN;
            DRAIN:   if (pipe_busy == '0) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        evt_ready_c = 1'b0;
        start       = 1'b0;
        issue       = 1'b0;
        finish      = 1'b0;
        unique case (state)
            IDLE: begin
                evt_ready_c = !bus.sample_tick;
                start       = bus.sample_tick;
            end
            ISSUE:   issue  = 1'b1;
            DRAIN:   finish = (pipe_busy == '0);
            default: ;
        endcase
    end

    // Same-note lookup doubles as the note-off clear mask
    always_comb begin
        hit        = 1'b0;
        hit_idx    = '0;
        free_found = 1'b0;
        free_idx   = '0;
        match_mask = '0;
        for (int unsigned v = 0; v < NUM_VOICES; v++) begin
            if (active[v] && (note[v] == bus.evt_note)) begin
                match_mask[v] = 1'b1;
                if (!hit) begin
                    hit     = 1'b1;
                    hit_idx = IDX_W'(v);
                end
            end
            if (!active[v] && !free_found) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(v);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active    <= '0;
            steal_ptr <= '0;
            for (int unsigned v = 0; v < NUM_VOICES; v++) begin
                note[v]  <= '0;
                freq[v]  <= '0;
                phase[v] <= '0;
            end
        end else begin
            if (finish) begin
                for (int unsigned v = 0; v < NUM_VOICES; v++) begin
                    if (active[v]) phase[v] <= phase[v] + freq[v];
                end
            end
            if (evt_fire) begin
                if (bus.evt_on) begin
                    active[on_idx] <= 1'b1;
                    note[on_idx]   <= bus.evt_note;
                    freq[on_idx]   <= bus.evt_freq;
                    phase[on_idx]  <= '0;
                    if (!hit && !free_found) steal_ptr <= steal_ptr + IDX_W'(1);
                end else begin
                    active <= active & ~match_mask;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            issue_idx    <= '0;
            bus.rom_addr <= '0;
            pipe_busy    <= '0;
            pipe_act     <= '0;
            acc          <= '0;
        end else begin
            if (start) begin
                bus.rom_addr <= phase[0][PHASE_W-1 -: ADDR_W];
                issue_idx    <= IDX_W'(1);
            end else if (issue) begin
                bus.rom_addr <= phase[issue_idx][PHASE_W-1 -: ADDR_W];
                issue_idx    <= issue_idx + IDX_W'(1);
            end
            pipe_busy[0] <= start || issue;
            pipe_act[0]  <= (start || issue) && push_act;
            for (int unsigned i = 1; i <= ROM_LAT; i++) begin
                pipe_busy[i] <= pipe_busy[i-1];
                pipe_act[i]  <= pipe_act[i-1];
            end
            if (start) begin
                acc <= '0;
            end else if (pipe_act[ROM_LAT]) begin
                acc <= acc + MIX_W'(bus.rom_data);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.mix_out      <= '0;
            bus.mix_valid    <= 1'b0;
            bus.steal        <= 1'b0;
            bus.tick_overrun <= 1'b0;
        end else begin
            if (finish) bus.mix_out <= acc;
            bus.mix_valid    <= finish;
            bus.steal        <= evt_fire && bus.evt_on && !hit && !free_found;
            bus.tick_overrun <= bus.sample_tick && (state != IDLE);
        end
    end
endmodule

// File: tb/tb_voice_scheduler.sv
// Directed bench for voice_scheduler; the ROM model returns its own address one cycle later,
// so each voice contributes phase >> 10 to the mix.
module tb_voice_scheduler;
    localparam int unsigned NUM_VOICES = 8;
    localparam int unsigned PHASE_W    = 32;
    localparam int unsigned ADDR_W     = 22;
    localparam int unsigned DATA_W     = 24;
    localparam int unsigned ROM_LAT    = 1;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    voice_scheduler_if #(
        .NUM_VOICES(NUM_VOICES),
        .PHASE_W   (PHASE_W),
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W)
    ) bus ();

    voice_scheduler #(
        .NUM_VOICES(NUM_VOICES),
        .PHASE_W   (PHASE_W),
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .ROM_LAT   (ROM_LAT)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always @(posedge clk) bus.rom_data <= DATA_W'(bus.rom_addr);

    typedef enum {OP_ON, OP_OFF, OP_FRAME} op_e;

    typedef struct {
        op_e         op;
        logic [6:0]  note;
        logic [31:0] freq;
        logic [7:0]  exp_active;
        logic        exp_steal;
        logic [26:0] exp_mix;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic send_event(input logic on, input logic [6:0] nt, input logic [31:0] fq,
                              input logic [7:0] exp_active, input logic exp_steal);
        int w;
        @(negedge clk);
        bus.evt_valid = 1'b1;
        bus.evt_on    = on;
        bus.evt_note  = nt;
        bus.evt_freq  = fq;
        w = 0;
        while (!bus.evt_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        check("evt_ready", 64'(bus.evt_ready), 64'd1);
        @(posedge clk);
        #1;
        bus.evt_valid = 1'b0;
        check("steal", 64'(bus.steal), 64'(exp_steal));
        check("voice_active", 64'(bus.voice_active), 64'(exp_active));
        @(posedge clk);
        #1;
        check("steal_pulse_end", 64'(bus.steal), 64'd0);
    endtask

    task automatic run_frame(input logic [26:0] exp_mix);
        int n;
        @(negedge clk);
        bus.sample_tick = 1'b1;
        @(posedge clk);
        #1;
        bus.sample_tick = 1'b0;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!bus.mix_valid && n < 30);
        check("frame_len", 64'(n), 64'd10);
        check("mix_out", 64'(bus.mix_out), 64'(exp_mix));
        check("evt_ready_mix_cycle", 64'(bus.evt_ready), 64'd1);
        @(posedge clk);
        #1;
        check("mix_valid_pulse_end", 64'(bus.mix_valid), 64'd0);
    endtask

    initial begin
        int n;
        int extra;
        logic [21:0] exp_addr [8];

        bus.sample_tick = 1'b0;
        bus.evt_valid   = 1'b0;
        bus.evt_on      = 1'b0;
        bus.evt_note    = '0;
        bus.evt_freq    = '0;
        reset           = 1'b1;

        // op, note, freq, expected voice_active, expected steal, expected mix_out
        vecs.push_back('{OP_FRAME, 7'd0,  32'h0,        8'h00, 1'b0, 27'd0});
        vecs.push_back('{OP_ON,    7'd60, 32'h00100000, 8'h01, 1'b0, 27'd0});
        vecs.push_back('{OP_FRAME, 7'd0,  32'h0,        8'h01, 1'b0, 27'd0});
        vecs.push_back('{OP_FRAME, 7'd0,  32'h0,        8'h01, 1'b0, 27'd1024});
        vecs.push_back('{OP_ON,    7'd61, 32'h00000400, 8'h03, 1'b0, 27'd0});
        vecs.push_back('{OP_ON,    7'd62, 32'h00000800, 8'h07, 1'b0, 27'd0});
        vecs.push_back('{OP_ON,    7'd63, 32'h00000C00, 8'h0F, 1'b0, 27'd0});
        vecs.push_back('{OP_ON,    7'd64, 32'h00001000, 8'h1F, 1'b0, 27'd0});
        vecs.push_back('{OP_ON,    7'd65, 32'h00001400, 8'h3F, 1'b0, 27'd0});
        vecs.push_back('{OP_ON,    7'd66, 32'h00001800, 8'h7F, 1'b0, 27'd0});
        vecs.push_back('{OP_ON,    7'd67, 32'h00001C00, 8'hFF, 1'b0, 27'd0});
        vecs.push_back('{OP_FRAME, 7'd0,  32'h0,        8'hFF, 1'b0, 27'd2048});
        vecs.push_back('{OP_FRAME, 7'd0,  32'h0,        8'hFF, 1'b0, 27'd3100});
        vecs.push_back('{OP_ON,    7'd70, 32'h00000400, 8'hFF, 1'b1, 27'd0});
        vecs.push_back('{OP_ON,    7'd71, 32'h00000000, 8'hFF, 1'b1, 27'd0});
        vecs.push_back('{OP_FRAME, 7'd0,  32'h0,        8'hFF, 1'b0, 27'd54});
        vecs.push_back('{OP_OFF,   7'd99, 32'h0,        8'hFF, 1'b0, 27'd0});
        vecs.push_back('{OP_OFF,   7'd63, 32'h0,        8'hF7, 1'b0, 27'd0});
        vecs.push_back('{OP_FRAME, 7'd0,  32'h0,        8'hF7, 1'b0, 27'd73});
        vecs.push_back('{OP_ON,    7'd62, 32'h00000400, 8'hF7, 1'b0, 27'd0});
        vecs.push_back('{OP_FRAME, 7'd0,  32'h0,        8'hF7, 1'b0, 27'd90});
        vecs.push_back('{OP_ON,    7'd63, 32'h00000C00, 8'hFF, 1'b0, 27'd0});
        vecs.push_back('{OP_FRAME, 7'd0,  32'h0,        8'hFF, 1'b0, 27'd114});

        repeat (2) @(posedge clk);
        #1;
        check("rst_voice_active", 64'(bus.voice_active), 64'd0);
        check("rst_mix_out",      64'(bus.mix_out),      64'd0);
        check("rst_mix_valid",    64'(bus.mix_valid),    64'd0);
        check("rst_steal",        64'(bus.steal),        64'd0);
        check("rst_tick_overrun", 64'(bus.tick_overrun), 64'd0);
        check("rst_rom_addr",     64'(bus.rom_addr),     64'd0);
        check("rst_evt_ready",    64'(bus.evt_ready),    64'd1);
        @(negedge clk);
        reset = 1'b0;

        foreach (vecs[i]) begin
            unique case (vecs[i].op)
                OP_ON:  send_event(1'b1, vecs[i].note, vecs[i].freq, vecs[i].exp_active, vecs[i].exp_steal);
                OP_OFF: send_event(1'b0, vecs[i].note, vecs[i].freq, vecs[i].exp_active, vecs[i].exp_steal);
                default: begin
                    run_frame(vecs[i].exp_mix);
                    check("active_after_frame", 64'(bus.voice_active), 64'(vecs[i].exp_active));
                end
            endcase
        end

        // Tick mid-frame: overrun pulse, frame result unchanged, no second frame
        @(negedge clk);
        bus.sample_tick = 1'b1;
        @(posedge clk);
        #1;
        bus.sample_tick = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        bus.sample_tick = 1'b1;
        @(posedge clk);
        #1;
        bus.sample_tick = 1'b0;
        check("tick_overrun", 64'(bus.tick_overrun), 64'd1);
        n = 4;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!bus.mix_valid && n < 30);
        check("overrun_frame_len", 64'(n), 64'd10);
        check("overrun_mix_out", 64'(bus.mix_out), 64'd141);
        check("overrun_pulse_end", 64'(bus.tick_overrun), 64'd0);
        extra = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (bus.mix_valid) extra++;
        end
        check("no_frame_from_overrun", 64'(extra), 64'd0);

        // Tick and note-off in the same IDLE cycle; also checks ROM address order
        exp_addr = '{22'd5, 22'd0, 22'd3, 22'd6, 22'd28, 22'd35, 22'd42, 22'd49};
        @(negedge clk);
        bus.sample_tick = 1'b1;
        bus.evt_valid   = 1'b1;
        bus.evt_on      = 1'b0;
        bus.evt_note    = 7'd64;
        #1;
        check("evt_ready_on_tick", 64'(bus.evt_ready), 64'd0);
        @(posedge clk);
        #1;
        bus.sample_tick = 1'b0;
        check("rom_addr_v0", 64'(bus.rom_addr), 64'(exp_addr[0]));
        for (int v = 1; v < 8; v++) begin
            @(posedge clk);
            #1;
            check($sformatf("rom_addr_v%0d", v), 64'(bus.rom_addr), 64'(exp_addr[v]));
        end
        check("held_evt_not_taken", 64'(bus.voice_active), 64'hFF);
        n = 7;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!bus.mix_valid && n < 30);
        check("held_frame_len", 64'(n), 64'd10);
        check("held_mix_out", 64'(bus.mix_out), 64'd168);
        check("held_evt_ready", 64'(bus.evt_ready), 64'd1);
        @(posedge clk);
        #1;
        bus.evt_valid = 1'b0;
        check("held_evt_applied", 64'(bus.voice_active), 64'hEF);

        // Reset in the middle of a frame: immediate clear, no mix_valid afterwards
        @(negedge clk);
        bus.sample_tick = 1'b1;
        @(posedge clk);
        #1;
        bus.sample_tick = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_active", 64'(bus.voice_active), 64'd0);
        check("async_rst_mix_out", 64'(bus.mix_out), 64'd0);
        check("async_rst_rom_addr", 64'(bus.rom_addr), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        extra = 0;
        repeat (15) begin
            @(posedge clk);
            #1;
            if (bus.mix_valid) extra++;
        end
        check("no_mix_after_rst", 64'(extra), 64'd0);
        check("evt_ready_after_rst", 64'(bus.evt_ready), 64'd1);

        // Phase wrap modulo 2^32
        send_event(1'b1, 7'd10, 32'hFFFFFC00, 8'h01, 1'b0);
        run_frame(27'd0);
        run_frame(27'h3FFFFF);
        run_frame(27'h3FFFFE);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/voice_scheduler.md
# voice_scheduler

Polyphonic voice scheduler for the wavetable synth. It owns the per-voice phase accumulators and allocates voices from MIDI-style note events. On each audio sample tick it time-multiplexes the single shared wavetable ROM port across all voices, then emits one summed mix sample. It sits between the SPI/MIDI command decoder (event source) and the wavetable ROM plus output DAC path.

## Interface
- NUM_VOICES, 8, number of voices (power of two, ≥2)
- PHASE_W, 32, phase accumulator width
- ADDR_W, 22, ROM address width; address = phase >> (PHASE_W-ADDR_W)
- DATA_W, 24, ROM sample width, unsigned
- ROM_LAT, 1, cycles from rom_addr change to valid rom_data
- clk  in  1  system clock; single clock domain
- reset  in  1  asynchronous, active-high reset
- sample_tick  in  1  one-cycle pulse that starts a sample frame
- evt_valid  in  1  note event present
- evt_ready  out  1  event accepted when evt_valid && evt_ready
- evt_on  in  1  1 = note on, 0 = note off
- evt_note  in  7  MIDI note number
- evt_freq  in  PHASE_W  phase increment per sample (note on only)
- rom_addr  out  ADDR_W  registered address to the shared wavetable ROM
- rom_data  in  DATA_W  ROM output
- mix_out  out  DATA_W+log2(NUM_VOICES)  registered sum of active voice samples
- mix_valid  out  1  one-cycle strobe: mix_out updated
- voice_active  out  NUM_VOICES  bit v = voice v sounding
- steal  out  1  one-cycle pulse: a note on stole a busy voice
- tick_overrun  out  1  one-cycle pulse: sample_tick arrived while a frame was in progress

## Operation
- Per-voice state: active, note[6:0], freq[PHASE_W-1:0], phase[PHASE_W-1:0]. There is also a steal pointer of log2(NUM_VOICES) bits.
- FSM states: IDLE, ISSUE, DRAIN.
- Event handling:
  - evt_ready = (state==IDLE) && !sample_tick.
  - Each accepted event is applied at the accepting edge.
- Note on, in priority order:
  - (a) An active voice with the same note is retriggered: phase←0, freq←evt_freq.
  - (b) Otherwise the lowest-index inactive voice gets active←1, note, freq, phase←0.
  - (c) Otherwise the voice at the steal pointer is overwritten as in (b). steal pulses and the pointer increments mod NUM_VOICES.
- Note off clears active on the voice whose active note matches. With no match it is a no-op; freq and phase are left untouched.
- IDLE + sample_tick → ISSUE.
  - The accumulator is cleared.
  - rom_addr ← address of voice 0 on the same edge.
- ISSUE:
  - On each following edge rom_addr advances to voice 1..N-1.
  - After voice N-1 is presented, go to DRAIN.
- Capture: rom_data for the voice presented in cycle c is added in cycle c+ROM_LAT. Inactive voices contribute 0.
- DRAIN: waits until the last voice is captured. On the final edge:
  - mix_out ← accumulator, mix_valid ← 1.
  - Every active voice gets phase ← phase + freq, mod 2^PHASE_W.
  - state ← IDLE.
- mix_out is unsigned, with no saturation; the width is sized for the full-scale sum of NUM_VOICES voices.
- sample_tick outside IDLE is ignored except for the tick_overrun pulse. The frame in progress completes unchanged.
- Reset values (asynchronous, applied immediately):
  - All voices inactive; note, freq and phase all 0.
  - Steal pointer 0, state IDLE, rom_addr 0, mix_out 0.
  - mix_valid, steal and tick_overrun all 0.
  - A frame interrupted by reset produces no mix_valid.

## Timing
- Tick sampled at edge T: rom_addr holds voice v from edge T+v.
- Last capture at edge T+NUM_VOICES+ROM_LAT.
- mix_valid is high for the one cycle after edge T+NUM_VOICES+ROM_LAT+1. With defaults this is edge T+10, giving a frame length of 10 cycles.
- evt_ready returns high in the mix_valid cycle.
- Minimum sample_tick spacing without overrun is NUM_VOICES+ROM_LAT+2 cycles.
- steal, tick_overrun and mix_valid are registered single-cycle pulses.
- voice_active updates on the edge after acceptance.

## Test plan
- Reset → every output is 0 and evt_ready=1. Release reset, then pulse sample_tick → mix_valid at T+10 with mix_out=0.
- ROM model rom_data=rom_addr (ROM_LAT=1). Note on 60 with freq=0x00100000, then two ticks:
  - First frame → mix_out=0.
  - Second frame → mix_out=1024 (0x100000>>10).
  - voice_active=0x01.
- Send 8 distinct note ons → voice_active=0xFF with no steal.
  - A 9th note on → steal pulse, voice 0 gets the new note.
  - A 10th note on → steal pulse, voice 1 is replaced.
- Note off for an unheld note → no state change. Note off for voice 3's note → bit 3 cleared and the next mix_out excludes that voice. Same-note note on → retrigger in place with phase 0 and no new voice.
- sample_tick at T+4 of a frame → tick_overrun pulse and the frame result is unchanged. sample_tick and evt_valid in the same IDLE cycle → evt_ready=0, frame starts, and the event is accepted in the mix_valid cycle.
- freq=0xFFFFFC00 from phase 0 → after one tick phase=0xFFFFFC00. After the second tick phase=0xFFFFF800 (wrapped), and the next mix_out=0x3FFFFE.
